aes_round_sequencer: RTL
========================

Name: aes_round_sequencer

Overview:
Top-level control FSM for the AES engine. It sequences the engine's three stages:
- counts 16 plaintext bytes from the input side into the plaintext register file;
- steps the round transformer through rounds 0..NR;
- raises transformer_done to the output interface and holds it until that interface reports the ciphertext fully read out.

It owns no datapath; it only issues strobes and indices.

Parameters:
NR, 10, number of full AES rounds (10/12/14 for AES-128/192/256); legal 10..14.
ROUND_CYCLES, 1, cycles the transformer needs per round; legal 1..8.

Ports:
clk  input  1  system clock, rising edge.
rst_  input  1  asynchronous, active-low reset.
in_valid  input  1  plaintext byte present on input side.
in_ready  output  1  sequencer accepts a byte this cycle.
byte_we  output  1  write strobe to plaintext register file.
byte_idx  output  4  byte slot (0..15) written when byte_we=1.
round_en  output  1  one-cycle pulse at start of each round.
round_idx  output  4  current round number, 0..NR.
init_add  output  1  high with round 0 (AddRoundKey only).
last_round  output  1  high with round NR (no MixColumns).
transformer_done  output  1  ciphertext valid, to output_interface.
output_read  input  1  output_interface has consumed all 16 bytes.
flush  input  1  synchronous abort to IDLE.
busy  output  1  any state other than IDLE.

Behaviour:
- States: IDLE, LOAD, RUN, DONE. All outputs are registered except byte_we.
- Reset (rst_ low, asynchronous):
  - state=IDLE, byte_idx=0, round_idx=0, cycle counter=0;
  - round_en=init_add=last_round=transformer_done=busy=0;
  - in_ready=1.
- Byte acceptance:
  - A byte is accepted when in_valid && in_ready && !flush.
  - byte_we = in_valid && in_ready && !flush, combinational.
  - byte_idx increments after each accepted byte.
  - in_ready=1 only in IDLE and LOAD.
- IDLE: first accepted byte writes slot 0, then moves to LOAD.
- LOAD:
  - gaps in in_valid are allowed; count and state are held;
  - on acceptance of slot 15, in_ready drops and state moves to RUN with round_idx=0;
  - byte_idx wraps to 0.
- RUN:
  - Each round lasts ROUND_CYCLES cycles.
  - round_en=1 only on the first cycle of a round. init_add and last_round are valid for the whole round.
  - round_idx increments at each round boundary.
  - After round NR's last cycle, state moves to DONE.
- Latency: with the last byte accepted on edge T:
  - round r starts at T+1+r·ROUND_CYCLES;
  - transformer_done rises at T+1+(NR+1)·ROUND_CYCLES.
- DONE:
  - transformer_done=1, held as a level; in_ready=0;
  - output_read is sampled only in DONE and ignored in every other state;
  - on output_read=1, next cycle: IDLE, transformer_done=0, in_ready=1;
  - output_read high on the cycle DONE is entered counts.
- flush:
  - From any state, next state is IDLE, counters are cleared, and all strobes are low next cycle.
  - Flush takes priority over in_valid and output_read in the same cycle; no byte is written.
- Back-to-back: the next block's first byte is accepted the cycle after DONE→IDLE. There is no input overlap with an in-flight block.
- round_idx width: 4 bits covers NR≤14; no wrap inside RUN.
- Reset mid-operation: immediate return to reset values; no partial strobe is emitted.

Test Plan:
1. Streaming load, default parameters:
   - Stimulus: reset, then 16 consecutive in_valid bytes.
   - byte_we pulses 16×, byte_idx 0..15.
   - round_en pulses 11 consecutive cycles, round_idx 0..10; init_add only at 0, last_round only at 10.
   - transformer_done rises 12 cycles after the last byte.
2. Gapped load:
   - Stimulus: in_valid toggles 1/0 for 32 cycles.
   - Exactly 16 writes, slots 0..15 in order.
   - No RUN entry before the 16th write.
3. ROUND_CYCLES=3, NR=14:
   - round_en spaced 3 cycles apart, 15 pulses, round_idx 0..14.
   - transformer_done at T+46.
4. Output hold and back-to-back:
   - Stimulus: output_read withheld 20 cycles after DONE, then pulsed once.
   - transformer_done stays 1 for the 20 cycles and falls the following cycle.
   - in_ready=1 that cycle; a second block loads and runs identically.
5. Flush mid-RUN (at round_idx=5) together with in_valid=1:
   - Next cycle IDLE, round_en=0, byte_we=0 in the flush cycle.
   - A fresh 16-byte load then completes normally.
6. rst_ asserted asynchronously mid-LOAD (byte_idx=7):
   - All outputs take reset values without waiting for a clock edge.
   - After release, loading restarts at slot 0.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// AES engine control sequencer: counts 16 plaintext bytes in, steps the round
// transformer through rounds 0..NR, then holds transformer_done until readout.
module aes_round_sequencer #(
  parameter int NR           = 10,
  parameter int ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       byte_we,
  output logic [3:0] byte_idx,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       init_add,
  output logic       last_round,
  output logic       transformer_done,
  input  logic       output_read,
  input  logic       flush,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [2:0] CYC_LAST   = 3'(ROUND_CYCLES - 1);
  localparam logic [3:0] ROUND_LAST = 4'(NR);

  state_t     state, state_nxt;
  logic [2:0] cyc_cnt, cyc_nxt;
  logic       armed, armed_nxt;
  logic [3:0] byte_idx_nxt, round_idx_nxt;
  logic       in_ready_nxt, round_en_nxt, init_add_nxt, last_round_nxt;
  logic       done_nxt, busy_nxt;

  assign byte_we = in_valid && in_ready && !flush;

  always_comb begin
    state_nxt      = state;
    byte_idx_nxt   = byte_idx;
    round_idx_nxt  = round_idx;
    cyc_nxt        = cyc_cnt;
    armed_nxt      = armed;
    round_en_nxt   = 1'b0;
    init_add_nxt   = init_add;
    last_round_nxt = last_round;
    done_nxt       = transformer_done;

    if (flush) begin
      state_nxt      = IDLE;
      byte_idx_nxt   = 4'd0;
      round_idx_nxt  = 4'd0;
      cyc_nxt        = 3'd0;
      armed_nxt      = 1'b0;
      init_add_nxt   = 1'b0;
      last_round_nxt = 1'b0;
      done_nxt       = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (byte_we) begin
            byte_idx_nxt = byte_idx + 4'd1;
            state_nxt    = LOAD;
          end
        end
        LOAD: begin
          if (byte_we) begin
            // 4-bit index wraps 15 -> 0 on the final byte
            byte_idx_nxt = byte_idx + 4'd1;
            if (byte_idx == 4'd15) begin
              state_nxt     = RUN;
              round_idx_nxt = 4'd0;
              cyc_nxt       = 3'd0;
              armed_nxt     = 1'b0;
            end
          end
        end
        RUN: begin
          // first RUN cycle only arms; round 0 is launched on the next edge
          if (!armed) begin
            armed_nxt      = 1'b1;
            round_en_nxt   = 1'b1;
            round_idx_nxt  = 4'd0;
            cyc_nxt        = 3'd0;
            init_add_nxt   = 1'b1;
            last_round_nxt = 1'b0;
          end else if (cyc_cnt == CYC_LAST) begin
            cyc_nxt = 3'd0;
            if (round_idx == ROUND_LAST) begin
              state_nxt      = DONE;
              armed_nxt      = 1'b0;
              init_add_nxt   = 1'b0;
              last_round_nxt = 1'b0;
              done_nxt       = 1'b1;
            end else begin
              round_idx_nxt  = round_idx + 4'd1;
              round_en_nxt   = 1'b1;
              init_add_nxt   = 1'b0;
              last_round_nxt = (round_idx + 4'd1) == ROUND_LAST;
            end
          end else begin
            cyc_nxt = cyc_cnt + 3'd1;
          end
        end
        DONE: begin
          if (output_read) begin
            state_nxt     = IDLE;
            round_idx_nxt = 4'd0;
            done_nxt      = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    in_ready_nxt = (state_nxt == IDLE) || (state_nxt == LOAD);
    busy_nxt     = state_nxt != IDLE;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state            <= IDLE;
      byte_idx         <= 4'd0;
      round_idx        <= 4'd0;
      cyc_cnt          <= 3'd0;
      armed            <= 1'b0;
      in_ready         <= 1'b1;
      round_en         <= 1'b0;
      init_add         <= 1'b0;
      last_round       <= 1'b0;
      transformer_done <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_nxt;
      byte_idx         <= byte_idx_nxt;
      round_idx        <= round_idx_nxt;
      cyc_cnt          <= cyc_nxt;
      armed            <= armed_nxt;
      in_ready         <= in_ready_nxt;
      round_en         <= round_en_nxt;
      init_add         <= init_add_nxt;
      last_round       <= last_round_nxt;
      transformer_done <= done_nxt;
      busy             <= busy_nxt;
    end
  end

endmodule
